pong_game_core: RTL and testbench



---
 rtl/pong_game_core.sv | 272 +++++++++++++++++++++++++++
 tb/tb_pong_game_core.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_core.sv
// Pong game-state engine: ball/paddle motion, scoring, opponent AI and game flow.
// Optional macro PONG_SPEEDUP_EN adds a ball speed that rises on every paddle hit.
module pong_game_core #(
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int COORD_W        = 10,
  parameter int BALL_SIZE      = 8,
  parameter int PADDLE_W       = 8,
  parameter int PADDLE_H       = 64,
  parameter int OPP_X          = 16,
  parameter int PLY_X          = 616,
  parameter int BALL_SPEED     = 2,
  parameter int PADDLE_SPEED   = 4,
  parameter int AI_SPEED       = 2,
  parameter int FRAME_DIV      = 1,
  parameter int SERVE_DELAY    = 60,
  parameter int SCORE_W        = 4,
  parameter int WIN_SCORE      = 9,
  parameter int BALL_SPEED_MAX = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_start,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y,
  output logic [COORD_W-1:0] paddle_y,
  output logic [COORD_W-1:0] op_paddle_y,
  output logic [SCORE_W-1:0] score_ply,
  output logic [SCORE_W-1:0] score_opp,
  output logic [2:0]         state,
  output logic               point_pulse,
  output logic               game_over
);
  // state   | meaning
  // S_IDLE  | waiting for btn_start, everything centred
  // S_SERVE | ball parked for SERVE_DELAY ticks, paddles live
  // S_PLAY  | ball moving, bounce / hit / miss checks
  // S_POINT | one tick: score, recentre, pick next state
  // S_OVER  | frozen until btn_start
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_SERVE = 3'd1, S_PLAY = 3'd2, S_POINT = 3'd3, S_OVER = 3'd4
  } state_t;

  localparam int BALL_X0    = (SCREEN_W - BALL_SIZE) / 2;
  localparam int BALL_Y0    = (SCREEN_H - BALL_SIZE) / 2;
  localparam int PAD_Y0     = (SCREEN_H - PADDLE_H) / 2;
  localparam int PAD_MAX    = SCREEN_H - PADDLE_H;
  localparam int BALL_X_MAX = SCREEN_W - BALL_SIZE;
  localparam int BALL_Y_MAX = SCREEN_H - BALL_SIZE;
  localparam int OPP_FACE   = OPP_X + PADDLE_W;
  localparam int SCORE_MAX  = (2 ** SCORE_W) - 1;

  state_t             state_q, state_d;
  logic [COORD_W-1:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic [COORD_W-1:0] paddle_y_q, paddle_y_d, op_paddle_y_q, op_paddle_y_d;
  logic [SCORE_W-1:0] score_ply_q, score_ply_d, score_opp_q, score_opp_d;
  logic               dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic               point_pulse_q, point_pulse_d, game_over_q, game_over_d;
  logic [7:0]         div_q, div_d;
  logic [15:0]        serve_cnt_q, serve_cnt_d;
  logic               tick;
  int                 bx, by, py, oy, spd, ai_diff;

  assign bx      = int'(ball_x_q);
  assign by      = int'(ball_y_q);
  assign py      = int'(paddle_y_q);
  assign oy      = int'(op_paddle_y_q);
  assign ai_diff = (by + BALL_SIZE / 2) - (oy + PADDLE_H / 2);

`ifdef PONG_SPEEDUP_EN
  logic [7:0] spd_q, spd_d;
  assign spd = int'(spd_q);
`else
  assign spd = (BALL_SPEED < BALL_SPEED_MAX) ? BALL_SPEED : BALL_SPEED_MAX;
`endif

  always_comb begin
    div_d = div_q;
    tick  = 1'b0;
    if (frame_tick) begin
      if (div_q == 8'(FRAME_DIV - 1)) begin
        tick  = 1'b1;
        div_d = '0;
      end else begin
        div_d = div_q + 8'd1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ball_x_d      = ball_x_q;
    ball_y_d      = ball_y_q;
    paddle_y_d    = paddle_y_q;
    op_paddle_y_d = op_paddle_y_q;
    score_ply_d   = score_ply_q;
    score_opp_d   = score_opp_q;
    dir_x_d       = dir_x_q;
    dir_y_d       = dir_y_q;
    serve_cnt_d   = serve_cnt_q;
    point_pulse_d = 1'b0;
`ifdef PONG_SPEEDUP_EN
    spd_d         = spd_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (btn_start) begin
          state_d     = S_SERVE;
          score_ply_d = '0;
          score_opp_d = '0;
          serve_cnt_d = '0;
        end
      end
      S_OVER: begin
        if (btn_start) begin
          state_d       = S_IDLE;
          ball_x_d      = COORD_W'(BALL_X0);
          ball_y_d      = COORD_W'(BALL_Y0);
          paddle_y_d    = COORD_W'(PAD_Y0);
          op_paddle_y_d = COORD_W'(PAD_Y0);
          score_ply_d   = '0;
          score_opp_d   = '0;
          dir_x_d       = 1'b1;
          dir_y_d       = 1'b1;
`ifdef PONG_SPEEDUP_EN
          spd_d         = 8'(BALL_SPEED);
`endif
        end
      end
      default: begin
        if (tick) begin
          if (btn_up && !btn_down)
            paddle_y_d = (py <= PADDLE_SPEED) ? '0 : COORD_W'(py - PADDLE_SPEED);
          else if (btn_down && !btn_up)
            paddle_y_d = (py + PADDLE_SPEED >= PAD_MAX) ? COORD_W'(PAD_MAX) : COORD_W'(py + PADDLE_SPEED);
          // AI deadband of +/-AI_SPEED keeps the paddle from dithering around the ball
          if (ai_diff > AI_SPEED)
            op_paddle_y_d = (oy + AI_SPEED >= PAD_MAX) ? COORD_W'(PAD_MAX) : COORD_W'(oy + AI_SPEED);
          else if (ai_diff < -AI_SPEED)
            op_paddle_y_d = (oy <= AI_SPEED) ? '0 : COORD_W'(oy - AI_SPEED);

          case (state_q)
            S_SERVE: begin
              serve_cnt_d = serve_cnt_q + 16'd1;
              if (int'(serve_cnt_q) + 1 >= SERVE_DELAY) state_d = S_PLAY;
            end
            S_PLAY: begin
              if (dir_y_q) begin
                if (by + spd >= BALL_Y_MAX) begin
                  ball_y_d = COORD_W'(BALL_Y_MAX);
                  dir_y_d  = 1'b0;
                end else begin
                  ball_y_d = COORD_W'(by + spd);
                end
              end else if (by <= spd) begin
                ball_y_d = '0;
                dir_y_d  = 1'b1;
              end else begin
                ball_y_d = COORD_W'(by - spd);
              end

              if (dir_x_q) begin
                if (bx + BALL_SIZE <= PLY_X && bx + BALL_SIZE + spd >= PLY_X &&
                    by + BALL_SIZE > py && by < py + PADDLE_H) begin
                  ball_x_d = COORD_W'(PLY_X - BALL_SIZE);
                  dir_x_d  = 1'b0;
`ifdef PONG_SPEEDUP_EN
                  if (spd < BALL_SPEED_MAX) spd_d = spd_q + 8'd1;
`endif
                end else if (bx + spd >= BALL_X_MAX) begin
                  state_d = S_POINT;
                end else begin
                  ball_x_d = COORD_W'(bx + spd);
                end
              end else begin
                if (bx >= OPP_FACE && bx - spd <= OPP_FACE &&
                    by + BALL_SIZE > oy && by < oy + PADDLE_H) begin
                  ball_x_d = COORD_W'(OPP_FACE);
                  dir_x_d  = 1'b1;
`ifdef PONG_SPEEDUP_EN
                  if (spd < BALL_SPEED_MAX) spd_d = spd_q + 8'd1;
`endif
                end else if (bx <= spd) begin
                  state_d = S_POINT;
                end else begin
                  ball_x_d = COORD_W'(bx - spd);
                end
              end
            end
            S_POINT: begin
              point_pulse_d = 1'b1;
              ball_x_d      = COORD_W'(BALL_X0);
              ball_y_d      = COORD_W'(BALL_Y0);
              dir_y_d       = ~dir_y_q;
`ifdef PONG_SPEEDUP_EN
              spd_d         = 8'(BALL_SPEED);
`endif
              // the ball is parked where it missed, so its side names the scorer
              if (bx < SCREEN_W / 2) begin
                dir_x_d = 1'b0;
                if (int'(score_ply_q) < SCORE_MAX) score_ply_d = score_ply_q + SCORE_W'(1);
              end else begin
                dir_x_d = 1'b1;
                if (int'(score_opp_q) < SCORE_MAX) score_opp_d = score_opp_q + SCORE_W'(1);
              end
              if (int'(score_ply_d) == WIN_SCORE || int'(score_opp_d) == WIN_SCORE) begin
                state_d = S_OVER;
              end else begin
                state_d     = S_SERVE;
                serve_cnt_d = '0;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
    game_over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ball_x_q      <= COORD_W'(BALL_X0);
      ball_y_q      <= COORD_W'(BALL_Y0);
      paddle_y_q    <= COORD_W'(PAD_Y0);
      op_paddle_y_q <= COORD_W'(PAD_Y0);
      score_ply_q   <= '0;
      score_opp_q   <= '0;
      dir_x_q       <= 1'b1;
      dir_y_q       <= 1'b1;
      point_pulse_q <= 1'b0;
      game_over_q   <= 1'b0;
      div_q         <= '0;
      serve_cnt_q   <= '0;
`ifdef PONG_SPEEDUP_EN
      spd_q         <= 8'(BALL_SPEED);
`endif
    end else begin
      state_q       <= state_d;
      ball_x_q      <= ball_x_d;
      ball_y_q      <= ball_y_d;
      paddle_y_q    <= paddle_y_d;
      op_paddle_y_q <= op_paddle_y_d;
      score_ply_q   <= score_ply_d;
      score_opp_q   <= score_opp_d;
      dir_x_q       <= dir_x_d;
      dir_y_q       <= dir_y_d;
      point_pulse_q <= point_pulse_d;
      game_over_q   <= game_over_d;
      div_q         <= div_d;
      serve_cnt_q   <= serve_cnt_d;
`ifdef PONG_SPEEDUP_EN
      spd_q         <= spd_d;
`endif
    end
  end

  assign ball_x      = ball_x_q;
  assign ball_y      = ball_y_q;
  assign paddle_y    = paddle_y_q;
  assign op_paddle_y = op_paddle_y_q;
  assign score_ply   = score_ply_q;
  assign score_opp   = score_opp_q;
  assign state       = state_q;
  assign point_pulse = point_pulse_q;
  assign game_over   = game_over_q;

endmodule

// File: tb/tb_pong_game_core.sv
// Scoreboard bench for pong_game_core: a game-level model predicts every cycle's outputs,
// a monitor compares them; directed checkpoints follow the documented game scenarios.
module tb_pong_game_core;
  localparam int SW = 640, SH = 480, BS = 8, PW = 8, PH = 64, OX = 16, PX = 616;
  localparam int SPD = 2, PSPD = 4, AIS = 2, FD = 2, SD = 4, WIN = 2, SMAX = 6, SCMAX = 15;
  localparam int BX0 = (SW - BS) / 2, BY0 = (SH - BS) / 2, PY0 = (SH - PH) / 2;
  localparam int ST_IDLE = 0, ST_SERVE = 1, ST_PLAY = 2, ST_POINT = 3, ST_OVER = 4;
`ifdef PONG_SPEEDUP_EN
  localparam int X147 = 605;
`else
  localparam int X147 = 606;
`endif

  logic clk = 1'b0, clk_en = 1'b1;
  logic rst_n, frame_tick, btn_up, btn_down, btn_start;
  logic [9:0] ball_x, ball_y, paddle_y, op_paddle_y;
  logic [3:0] score_ply, score_opp;
  logic [2:0] state;
  logic       point_pulse, game_over;

  pong_game_core #(.FRAME_DIV(FD), .SERVE_DELAY(SD), .WIN_SCORE(WIN)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .btn_up(btn_up),
    .btn_down(btn_down), .btn_start(btn_start), .ball_x(ball_x), .ball_y(ball_y),
    .paddle_y(paddle_y), .op_paddle_y(op_paddle_y), .score_ply(score_ply),
    .score_opp(score_opp), .state(state), .point_pulse(point_pulse), .game_over(game_over)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  typedef struct packed {
    logic [9:0] bx, by, py, oy;
    logic [3:0] sp, so;
    logic [2:0] st;
    logic       pp, go;
  } snap_t;

  snap_t exp_q[$];
  int n_assert = 0, n_fail = 0;

  // game model
  int m_bx, m_by, m_py, m_oy, m_sp, m_so, m_st, m_div, m_cnt, m_spd;
  bit m_dx, m_dy, m_pp, m_scorer_ply, m_tick, m_play_tick;
  int play_ticks = 0;
  bit prev_ft = 0, r_up = 0, r_dn = 0;

  function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction
  function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction

  task automatic model_reset_game();
    m_bx = BX0; m_by = BY0; m_py = PY0; m_oy = PY0;
    m_sp = 0; m_so = 0; m_st = ST_IDLE; m_dx = 1; m_dy = 1; m_spd = SPD;
  endtask

  task automatic model_reset();
    model_reset_game();
    m_div = 0; m_cnt = 0; m_pp = 0;
  endtask

  task automatic model_step(input bit ft, input bit up, input bit dn, input bit st);
    int bx, by, py, oy, d;
    bit hit;
    bx = m_bx; by = m_by; py = m_py; oy = m_oy; hit = 0;
    m_tick = 0; m_play_tick = 0; m_pp = 0;
    if (ft) begin
      if (m_div == FD - 1) begin m_tick = 1; m_div = 0; end
      else m_div++;
    end
    if (m_st == ST_IDLE) begin
      if (st) begin m_st = ST_SERVE; m_sp = 0; m_so = 0; m_cnt = 0; end
    end else if (m_st == ST_OVER) begin
      if (st) model_reset_game();
    end else if (m_tick) begin
      if (up && !dn) m_py = imax(py - PSPD, 0);
      else if (dn && !up) m_py = imin(py + PSPD, SH - PH);
      d = (by + BS / 2) - (oy + PH / 2);
      if (d > AIS) m_oy = imin(oy + AIS, SH - PH);
      else if (d < -AIS) m_oy = imax(oy - AIS, 0);
      if (m_st == ST_SERVE) begin
        m_cnt++;
        if (m_cnt == SD) m_st = ST_PLAY;
      end else if (m_st == ST_PLAY) begin
        play_ticks++; m_play_tick = 1;
        if (m_dy) begin
          if (by + m_spd >= SH - BS) begin m_by = SH - BS; m_dy = 0; end
          else m_by = by + m_spd;
        end else if (by <= m_spd) begin m_by = 0; m_dy = 1; end
        else m_by = by - m_spd;
        if (m_dx) begin
          if (bx + BS <= PX && bx + BS + m_spd >= PX && by + BS > py && by < py + PH) begin
            m_bx = PX - BS; m_dx = 0; hit = 1;
          end else if (bx + m_spd >= SW - BS) begin m_st = ST_POINT; m_scorer_ply = 0; end
          else m_bx = bx + m_spd;
        end else begin
          if (bx >= OX + PW && bx - m_spd <= OX + PW && by + BS > oy && by < oy + PH) begin
            m_bx = OX + PW; m_dx = 1; hit = 1;
          end else if (bx <= m_spd) begin m_st = ST_POINT; m_scorer_ply = 1; end
          else m_bx = bx - m_spd;
        end
`ifdef PONG_SPEEDUP_EN
        if (hit) m_spd = imin(m_spd + 1, SMAX);
`endif
      end else begin
        m_pp = 1; m_bx = BX0; m_by = BY0; m_dy = !m_dy; m_spd = SPD;
        m_dx = m_scorer_ply ? 1'b0 : 1'b1;
        if (m_scorer_ply) m_sp = imin(m_sp + 1, SCMAX);
        else m_so = imin(m_so + 1, SCMAX);
        if ((m_scorer_ply ? m_sp : m_so) == WIN) m_st = ST_OVER;
        else begin m_st = ST_SERVE; m_cnt = 0; end
      end
    end
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s.bx = 10'(m_bx); s.by = 10'(m_by); s.py = 10'(m_py); s.oy = 10'(m_oy);
    s.sp = 4'(m_sp); s.so = 4'(m_so); s.st = 3'(m_st); s.pp = m_pp; s.go = (m_st == ST_OVER);
    return s;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle(input bit ft, input bit up, input bit dn, input bit st);
    frame_tick = ft; btn_up = up; btn_down = dn; btn_start = st;
    model_step(ft, up, dn, st);
    exp_q.push_back(model_snap());
    @(negedge clk);
  endtask

  task automatic rand_cycle(input bit allow_start);
    bit ft, st;
    ft = !prev_ft && (1'($urandom_range(0, 1)) == 1'b1);
    prev_ft = ft;
    if ($urandom_range(0, 31) == 0) begin
      r_up = 1'($urandom_range(0, 1));
      r_dn = 1'($urandom_range(0, 1));
    end
    st = allow_start && ($urandom_range(0, 63) == 0);
    cycle(ft, r_up, r_dn, st);
  endtask

  task automatic chk_reset_values();
    chk("rst_ball_x", int'(ball_x), BX0);
    chk("rst_ball_y", int'(ball_y), BY0);
    chk("rst_paddle_y", int'(paddle_y), PY0);
    chk("rst_op_paddle_y", int'(op_paddle_y), PY0);
    chk("rst_score_ply", int'(score_ply), 0);
    chk("rst_score_opp", int'(score_opp), 0);
    chk("rst_state", int'(state), ST_IDLE);
    chk("rst_point_pulse", int'(point_pulse), 0);
    chk("rst_game_over", int'(game_over), 0);
  endtask

  // monitor: every posedge that follows a stimulus step has one expected snapshot queued
  always begin
    snap_t a, e;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = '{ball_x, ball_y, paddle_y, op_paddle_y, score_ply, score_opp, state, point_pulse, game_over};
      n_assert++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t: got bx=%0d by=%0d py=%0d oy=%0d sp=%0d so=%0d st=%0d pp=%0d go=%0d, expected bx=%0d by=%0d py=%0d oy=%0d sp=%0d so=%0d st=%0d pp=%0d go=%0d",
                 $time, a.bx, a.by, a.py, a.oy, a.sp, a.so, a.st, a.pp, a.go,
                 e.bx, e.by, e.py, e.oy, e.sp, e.so, e.st, e.pp, e.go);
      end
    end
  end

  initial begin
    int ticks, pt0, fbx, fby, fpy, foy;
    bit ft, got;
    rst_n = 1'b1; frame_tick = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_start = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    #2 chk_reset_values();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // directed game: serve, wall bounce, player hit, then player miss
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    ticks = 0; got = 0; ft = 0;
    for (int i = 0; i < 6000 && !got; i++) begin
      ft = !ft;
      cycle(ft, play_ticks >= 147, ticks < 44, 1'b0);
      if (m_tick) begin
        ticks++;
        if (ticks == SD) chk("serve_to_play", int'(state), ST_PLAY);
      end
      if (m_play_tick) begin
        case (play_ticks)
          1:   begin chk("play1_ball_x", int'(ball_x), 318); chk("play1_ball_y", int'(ball_y), 238); end
          118: chk("wall_ball_y", int'(ball_y), 472);
          119: chk("wall_rebound_y", int'(ball_y), 470);
          146: begin chk("hit_ball_x", int'(ball_x), 608); chk("hit_ball_y", int'(ball_y), 416);
                     chk("hit_paddle_y", int'(paddle_y), 384); end
          147: chk("hit_rebound_x", int'(ball_x), X147);
          default: ;
        endcase
      end
      if (m_pp) begin
        got = 1;
        chk("miss_pulse", int'(point_pulse), 1);
        chk("miss_score_opp", int'(score_opp), 1);
        chk("miss_state", int'(state), ST_SERVE);
        chk("miss_ball_x", int'(ball_x), BX0);
        chk("miss_ball_y", int'(ball_y), BY0);
      end
    end
    chk("first_point_seen", int'(got), 1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("pulse_single_cycle", int'(point_pulse), 0);

    // random play until the game ends
    got = 0;
    for (int i = 0; i < 30000 && !got; i++) begin
      rand_cycle(1'b1);
      if (m_st == ST_OVER) got = 1;
    end
    chk("game_over_reached", int'(got), 1);
    if (got) begin
      chk("over_flag", int'(game_over), 1);
      chk("over_state", int'(state), ST_OVER);
      fbx = m_bx; fby = m_by; fpy = m_py; foy = m_oy;
      repeat (60) rand_cycle(1'b0);
      chk("frozen_ball_x", int'(ball_x), fbx);
      chk("frozen_ball_y", int'(ball_y), fby);
      chk("frozen_paddle_y", int'(paddle_y), fpy);
      chk("frozen_op_paddle_y", int'(op_paddle_y), foy);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      chk("restart_state", int'(state), ST_IDLE);
      chk("restart_score_ply", int'(score_ply), 0);
      chk("restart_score_opp", int'(score_opp), 0);
      chk("restart_game_over", int'(game_over), 0);
      chk("restart_ball_x", int'(ball_x), BX0);
    end

    // new game, then asynchronous reset mid-play with the clock stopped
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    pt0 = play_ticks;
    for (int i = 0; i < 3000 && play_ticks < pt0 + 20; i++) rand_cycle(1'b0);
    chk("pre_reset_state", int'(state), ST_PLAY);
    clk_en = 1'b0;
    frame_tick = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_start = 1'b0;
    #3 rst_n = 1'b0;
    #1 chk_reset_values();
    model_reset();
    #4 rst_n = 1'b1;
    #2 chk("post_release_state", int'(state), ST_IDLE);
    clk_en = 1'b1;
    @(negedge clk);
    repeat (40) rand_cycle(1'b0);
    chk("idle_hold_ball_x", int'(ball_x), BX0);
    chk("idle_hold_paddle_y", int'(paddle_y), PY0);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
